// File: rtl/ws28xx_ctrl.sv
// ============================================================================
// ws28xx_ctrl
// ----------------------------------------------------------------------------
// Frame controller for WS28xx-style addressable LED strings. It pulls pixel
// bytes from an upstream source, serialises them MSB first into single-bit
// requests for a downstream bit-code generator, and then holds the line idle
// for a programmable latch (reset) gap before signalling frame completion.
//
// Build option:
//   WS28XX_CTRL_RGBW_EN  defined   -> 4 bytes per LED (GRBW, 32 bits/LED)
//                        undefined -> 3 bytes per LED (GRB, 24 bits/LED)
//
// Parameters:
//   GAP_W         width of the latch-gap counter and rst_time_i
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_n_i       asynchronous active-low reset
//   start_i       frame start request, only honoured in IDLE
//   led_num_i     LEDs per frame, captured when a start is accepted
//   rst_time_i    latch-gap length in clock cycles, captured on start
//   byte_data_i   pixel byte from upstream
//   byte_valid_i  byte_data_i is valid
//   byte_ready_o  controller takes a byte this cycle (LOAD state)
//   bit_data_o    current bit for the generator (held for the whole bit)
//   bit_valid_o   bit request to the generator (SEND state)
//   bit_ready_i   one-cycle pulse from the generator at end of a bit
//   busy_o        high whenever the controller is not IDLE
//   done_o        one-cycle pulse after the latch gap has elapsed
// ============================================================================
module ws28xx_ctrl #(
   parameter int GAP_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [7:0]       led_num_i,
   input  logic [GAP_W-1:0] rst_time_i,
   input  logic [7:0]       byte_data_i,
   input  logic             byte_valid_i,
   output logic             byte_ready_o,
   output logic             bit_data_o,
   output logic             bit_valid_o,
   input  logic             bit_ready_i,
   output logic             busy_o,
   output logic             done_o
);

`ifdef WS28XX_CTRL_RGBW_EN
   localparam int BPP = 4;
`else
   localparam int BPP = 3;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t           state;
   logic [7:0]       led_num;
   logic [GAP_W-1:0] rst_time;
   logic [GAP_W-1:0] gap_cnt;
   logic [7:0]       shift;
   logic [2:0]       bit_cnt;
   logic [9:0]       byte_cnt;
   logic [9:0]       byte_total;

   // 255 LEDs x 4 bytes = 1020 still fits in 10 bits, so no wrap is possible.
   assign byte_total = 10'(led_num) * 10'(BPP);

   // Outputs are registered alongside the state: every transition sets the
   // output values that belong to the state being entered, so bit_data_o is
   // loaded with the next MSB exactly when the shift register advances and
   // stays put for the generator until the next bit_ready_i.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= IDLE;
         led_num      <= '0;
         rst_time     <= '0;
         gap_cnt      <= '0;
         shift        <= '0;
         bit_cnt      <= '0;
         byte_cnt     <= '0;
         byte_ready_o <= 1'b0;
         bit_data_o   <= 1'b0;
         bit_valid_o  <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  led_num  <= led_num_i;
                  rst_time <= rst_time_i;
                  gap_cnt  <= '0;
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
                  busy_o   <= 1'b1;
                  // An empty frame still produces a latch gap and done pulse.
                  if (led_num_i != 8'd0) begin
                     state        <= LOAD;
                     byte_ready_o <= 1'b1;
                  end else begin
                     state <= GAP;
                  end
               end
            end

            LOAD: begin
               if (byte_valid_i) begin
                  shift        <= byte_data_i;
                  bit_cnt      <= '0;
                  bit_data_o   <= byte_data_i[7];
                  bit_valid_o  <= 1'b1;
                  byte_ready_o <= 1'b0;
                  state        <= SEND;
               end
            end

            SEND: begin
               if (bit_ready_i) begin
                  if (bit_cnt == 3'd7) begin
                     byte_cnt    <= byte_cnt + 10'd1;
                     bit_valid_o <= 1'b0;
                     bit_data_o  <= 1'b0;
                     if (byte_cnt + 10'd1 == byte_total) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                     end else begin
                        byte_ready_o <= 1'b1;
                        state        <= LOAD;
                     end
                  end else begin
                     shift      <= {shift[6:0], 1'b0};
                     bit_cnt    <= bit_cnt + 3'd1;
                     bit_data_o <= shift[6];
                  end
               end
            end

            GAP: begin
               // Counter starts at 0, so the gap lasts rst_time + 1 cycles.
               if (gap_cnt == rst_time) begin
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  state  <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ws28xx_ctrl.sv
// ============================================================================
// tb_ws28xx_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for ws28xx_ctrl. A table of frame descriptions drives
// an upstream byte source and a bit-code generator model; every accepted byte
// pushes its eight expected bits (MSB first) onto a queue that is popped and
// compared at each generator handshake. Hand-written sequences cover the
// mid-frame reset case.
// ============================================================================
`timescale 1ns/1ps
module tb_ws28xx_ctrl;

`ifdef WS28XX_CTRL_RGBW_EN
   localparam int BPP = 4;
`else
   localparam int BPP = 3;
`endif
   localparam int GAP_W       = 16;
   localparam int CYCLE_LIMIT = 40000;
   localparam int NUM_VECS    = 7;

   logic             clk_i        = 1'b0;
   logic             rst_n_i      = 1'b0;
   logic             start_i      = 1'b0;
   logic [7:0]       led_num_i    = '0;
   logic [GAP_W-1:0] rst_time_i   = '0;
   logic [7:0]       byte_data_i  = '0;
   logic             byte_valid_i = 1'b0;
   logic             byte_ready_o;
   logic             bit_data_o;
   logic             bit_valid_o;
   logic             bit_ready_i  = 1'b0;
   logic             busy_o;
   logic             done_o;

   ws28xx_ctrl #(.GAP_W(GAP_W)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .start_i      (start_i),
      .led_num_i    (led_num_i),
      .rst_time_i   (rst_time_i),
      .byte_data_i  (byte_data_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .bit_data_o   (bit_data_o),
      .bit_valid_o  (bit_valid_o),
      .bit_ready_i  (bit_ready_i),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   // 10 ns clock
   always #5 clk_i = ~clk_i;

   // One frame description plus the results it must produce.
   typedef struct {
      int led;
      int rst;
      int lat;
      int stall_after;
      int stall_len;
      bit fixed;
      bit poke;
      bit chain;
      int exp_bytes;
      int exp_bits;
      int exp_gap;
      int exp_busy;
   } vec_t;

   vec_t       vecs[NUM_VECS];
   logic [7:0] fixedBytes[3];
   bit         expQ[$];

   int vecCount  = 0;
   int missCount = 0;

   int bytesSent, bitsSeen, gapCycles, busyCycles, doneCount;
   bit timedOut;

   // Every comparison goes through here.
   task automatic checkOutput(input string name, input int actual, input int expected);
      vecCount++;
      if (actual != expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Runs one frame from the current negedge. The caller is positioned on a
   // negedge; the task returns on the negedge where done_o is seen, or early
   // once abortBits handshakes have happened (abortBits = 0 means never).
   task automatic applyStimulus(input vec_t v, input int abortBits);
      int         waitCnt;
      int         stallLeft;
      int         cyc;
      bit         gapPoked;
      logic [7:0] b;
      bytesSent  = 0;
      bitsSeen   = 0;
      gapCycles  = 0;
      busyCycles = 0;
      doneCount  = 0;
      timedOut   = 1'b0;
      waitCnt    = 0;
      stallLeft  = v.stall_len;
      gapPoked   = 1'b0;
      led_num_i  = 8'(v.led);
      rst_time_i = GAP_W'(v.rst);
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      checkOutput("busy_after_start", int'(busy_o), 1);
      for (cyc = 0; cyc < CYCLE_LIMIT; cyc++) begin
         start_i      = 1'b0;
         byte_valid_i = 1'b0;
         if (done_o) begin
            doneCount++;
            break;
         end
         if (busy_o) busyCycles++;
         if (!bit_valid_o) checkOutput("bit_data_outside_send", int'(bit_data_o), 0);

         // Latch gap: busy with neither a byte nor a bit being requested.
         if (busy_o && !byte_ready_o && !bit_valid_o) begin
            gapCycles++;
            if (v.poke && !gapPoked) begin
               start_i   = 1'b1;
               led_num_i = 8'd7;
               gapPoked  = 1'b1;
            end
         end

         // Upstream byte source with optional stall.
         if (byte_ready_o) begin
            if (bytesSent == v.stall_after && stallLeft > 0) begin
               stallLeft--;
               checkOutput("bit_valid_in_stall", int'(bit_valid_o), 0);
            end else begin
               b = v.fixed ? fixedBytes[bytesSent % 3] : 8'($urandom);
               byte_data_i  = b;
               byte_valid_i = 1'b1;
               bytesSent++;
               for (int k = 7; k >= 0; k--) expQ.push_back(b[k]);
            end
         end

         // Bit-code generator model: ready pulse lat cycles into each bit.
         if (bit_ready_i) begin
            bit_ready_i = 1'b0;
            waitCnt     = 0;
         end else if (bit_valid_o) begin
            checkOutput("bit_expected", int'(expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
               checkOutput("bit_data", int'(bit_data_o), int'(expQ[0]));
               if (waitCnt >= v.lat - 1) begin
                  bit_ready_i = 1'b1;
                  void'(expQ.pop_front());
                  bitsSeen++;
                  if (v.poke && bitsSeen == 3) begin
                     start_i   = 1'b1;
                     led_num_i = 8'd7;
                  end
               end else begin
                  waitCnt++;
               end
            end
         end

         if (abortBits != 0 && bitsSeen >= abortBits) break;
         @(negedge clk_i);
      end
      if (cyc >= CYCLE_LIMIT) timedOut = 1'b1;
   endtask

   // Compares the measured results of a finished frame with its table row.
   task automatic checkFrame(input vec_t v);
      checkOutput("frame_timeout", int'(timedOut), 0);
      checkOutput("bytes_taken", bytesSent, v.exp_bytes);
      checkOutput("bit_handshakes", bitsSeen, v.exp_bits);
      checkOutput("bits_left_over", expQ.size(), 0);
      checkOutput("gap_cycles", gapCycles, v.exp_gap);
      checkOutput("done_pulses", doneCount, 1);
      if (v.exp_busy >= 0) checkOutput("busy_cycles", busyCycles, v.exp_busy);
   endtask

   initial begin
      vec_t rv;

      fixedBytes[0] = 8'hA5;
      fixedBytes[1] = 8'h0F;
      fixedBytes[2] = 8'hF0;
      //         led  rst lat stA stL fix pok chn bytes        bits             gap busy
      vecs[0] = '{1,   10, 5,  -1, 0,  1,  0,  0,  1*BPP,       1*BPP*8,         11, -1};
      vecs[1] = '{0,   3,  5,  -1, 0,  0,  0,  0,  0,           0,               4,  4};
      vecs[2] = '{2,   5,  2,  3,  20, 0,  0,  0,  2*BPP,       2*BPP*8,         6,  -1};
      vecs[3] = '{1,   4,  3,  -1, 0,  0,  1,  0,  1*BPP,       1*BPP*8,         5,  -1};
      vecs[4] = '{1,   0,  1,  -1, 0,  0,  0,  1,  1*BPP,       1*BPP*8,         1,  -1};
      vecs[5] = '{3,   2,  1,  -1, 0,  0,  0,  0,  3*BPP,       3*BPP*8,         3,  -1};
      vecs[6] = '{255, 20, 1,  -1, 0,  0,  0,  0,  255*BPP,     255*BPP*8,       21, -1};

      // Reset state.
      repeat (2) @(negedge clk_i);
      checkOutput("reset_byte_ready", int'(byte_ready_o), 0);
      checkOutput("reset_bit_valid", int'(bit_valid_o), 0);
      checkOutput("reset_bit_data", int'(bit_data_o), 0);
      checkOutput("reset_busy", int'(busy_o), 0);
      checkOutput("reset_done", int'(done_o), 0);
      rst_n_i = 1'b1;

      for (int i = 0; i < NUM_VECS; i++) begin
         if (!vecs[i].chain) begin
            @(negedge clk_i);
            checkOutput("idle_done_low", int'(done_o), 0);
            checkOutput("idle_busy_low", int'(busy_o), 0);
         end
         expQ.delete();
         applyStimulus(vecs[i], 0);
         checkFrame(vecs[i]);
      end

      // Reset asserted in the middle of a byte.
      @(negedge clk_i);
      rv = '{1, 5, 5, -1, 0, 0, 0, 0, 1*BPP, 1*BPP*8, 6, -1};
      expQ.delete();
      applyStimulus(rv, 12);
      checkOutput("mid_frame_bit_valid", int'(bit_valid_o), 1);
      #2 rst_n_i = 1'b0;
      #1;
      checkOutput("async_reset_byte_ready", int'(byte_ready_o), 0);
      checkOutput("async_reset_bit_valid", int'(bit_valid_o), 0);
      checkOutput("async_reset_bit_data", int'(bit_data_o), 0);
      checkOutput("async_reset_busy", int'(busy_o), 0);
      checkOutput("async_reset_done", int'(done_o), 0);
      bit_ready_i  = 1'b0;
      byte_valid_i = 1'b0;
      start_i      = 1'b0;
      expQ.delete();
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      rv = '{1, 2, 2, -1, 0, 1, 0, 0, 1*BPP, 1*BPP*8, 3, -1};
      applyStimulus(rv, 0);
      checkFrame(rv);

      @(negedge clk_i);
      checkOutput("final_done_low", int'(done_o), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
